rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter CH_NUM, 3, number of sequenced reset channels (1..8).
REQ-002 Parameter CNT_W, 20, cycle-counter width in bits.
REQ-003 Parameter DELAY, 20'h0fff0, cycles from lock to channel-0 release (>=1).
REQ-004 Parameter STEP, 20'h01000, extra cycles between consecutive channel releases (0 allowed).
REQ-005 clk_i  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 lock_i  input  1  clock-source locked; level, may be asynchronous to clk_i.
REQ-008 retrig_i  input  1  restart request, level-sampled, synchronous to clk_i.
REQ-009 rst_o  output  CH_NUM  per-channel reset, active-high, registered; bit k = channel k.
REQ-010 done_o  output  1  all channels released, registered.

Function
REQ-011 Release time of channel k SHALL be T_k = DELAY + k*STEP; T_last = T_(CH_NUM-1).
REQ-012 Parameters SHALL satisfy T_last < 2^CNT_W; the counter SHALL saturate at T_last and never wrap.
REQ-013 FSM states SHALL be S_WAIT, S_CNT, S_DONE.
REQ-014 S_WAIT: cnt=0, rst_o all ones, done_o=0; go to S_CNT on an edge where lock (after optional sync) = 1 and retrig_i = 0.
REQ-015 Edge E0 = edge entering S_CNT; after edge E0+j (j>=0), rst_o[k] SHALL be 1 iff j < T_k.
REQ-016 After edge E0+T_last: state S_DONE, done_o=1, rst_o all zeros, cnt held at T_last.
REQ-017 S_DONE SHALL hold outputs until lock loss or retrig_i.
REQ-018 In S_CNT or S_DONE, lock=0 or retrig_i=1 sampled at an edge SHALL, at that edge, move to S_WAIT, set rst_o all ones, done_o=0, cnt=0.
REQ-019 Lock loss and retrig_i together SHALL behave as either alone; both SHALL take priority over counting and release.
REQ-020 retrig_i held high SHALL keep the block in S_WAIT; counting restarts on the first edge with retrig_i=0 and lock=1.
REQ-021 STEP=0 SHALL release all channels on the same edge E0+DELAY.
REQ-022 rst_o bits SHALL be flop outputs: glitch-free, each bit changes at most once per sequence.
REQ-023 Once released, a channel SHALL only be re-asserted by transition to S_WAIT, never individually.

Reset
REQ-024 rst_n_i low SHALL immediately force S_WAIT, cnt=0, rst_o all ones, done_o=0, synchroniser flops 0.
REQ-025 Release of rst_n_i SHALL behave as entry to S_WAIT; reset asserted mid-sequence SHALL abort it with no partial release.

Configuration
REQ-026 Macro RST_SEQ_LOCK_SYNC_EN defined: lock_i passes through a two-flop synchroniser on clk_i; E0 occurs 2 edges later than without it.
REQ-027 Macro RST_SEQ_LOCK_SYNC_EN undefined: lock_i used directly; it SHALL be synchronous to clk_i.
REQ-028 Lock-loss response SHALL also incur the 2-edge synchroniser latency when the macro is defined.

Verification (CH_NUM=3, CNT_W=4, DELAY=4, STEP=3, macro undefined unless stated)
REQ-029 lock_i 0->1 before edge E0 -> rst_o 3'b111 until E0+4, 3'b110 at E0+4, 3'b100 at E0+7, 3'b000 and done_o=1 at E0+10.
REQ-030 lock_i dropped 1 cycle before E0+8 -> rst_o=3'b111, done_o=0 at E0+8; relock restarts full 4/7/10 sequence.
REQ-031 retrig_i high 3 cycles while in S_DONE -> rst_o=3'b111 for 3 cycles, then re-release at 4/7/10 after the restart edge.
REQ-032 rst_n_i pulsed low mid-cycle at E0+5 -> rst_o=3'b111, done_o=0 immediately, without waiting for a clock edge; sequence restarts after release.
REQ-033 STEP=0 -> rst_o 3'b111 to 3'b000 on edge E0+4, done_o=1 same edge.
REQ-034 RST_SEQ_LOCK_SYNC_EN defined -> every release and lock-loss response in REQ-029/030 occurs 2 edges later.

Source files
------------

// File: rtl/rst_seq.sv
// Sequenced reset release: after clock lock, channel k leaves reset DELAY + k*STEP cycles later.
// Define RST_SEQ_LOCK_SYNC_EN to pass lock_i through a two-flop synchroniser on clk_i.
module rst_seq #(
  parameter int unsigned      CH_NUM = 3,
  parameter int unsigned      CNT_W  = 20,
  parameter logic [CNT_W-1:0] DELAY  = CNT_W'(20'h0fff0),
  parameter logic [CNT_W-1:0] STEP   = CNT_W'(20'h01000)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lock_i,
  input  logic              retrig_i,
  output logic [CH_NUM-1:0] rst_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] T_LAST = DELAY + CNT_W'(CH_NUM - 1) * STEP;

  typedef enum logic [1:0] {
    S_WAIT,
    S_CNT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic [CNT_W-1:0]  w_cntInc;
  logic [CH_NUM-1:0] r_rst;
  logic [CH_NUM-1:0] w_rstNext;
  logic [CH_NUM-1:0] w_relHit;
  logic              r_done;
  logic              w_doneNext;
  logic              w_lock;
  logic              w_abort;

`ifdef RST_SEQ_LOCK_SYNC_EN
  logic r_lockS1;
  logic r_lockS2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lockS1 <= 1'b0;
      r_lockS2 <= 1'b0;
    end else begin
      r_lockS1 <= lock_i;
      r_lockS2 <= r_lockS1;
    end
  end

  assign w_lock = r_lockS2;
`else
  assign w_lock = lock_i;
`endif

  assign w_abort  = !w_lock || retrig_i;
  assign w_cntInc = r_cnt + CNT_W'(1);

  // Each channel's release threshold is a constant; a hit means the next count reaches it.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_rel
    localparam logic [CNT_W-1:0] REL_T = DELAY + CNT_W'(g) * STEP;
    assign w_relHit[g] = (w_cntInc >= REL_T);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_rst   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_rst   <= w_rstNext;
      r_done  <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_rstNext   = r_rst;
    w_doneNext  = r_done;
    case (r_state)
      S_WAIT: begin
        w_cntNext  = '0;
        w_rstNext  = '1;
        w_doneNext = 1'b0;
        if (!w_abort) begin
          w_stateNext = S_CNT;
        end
      end
      S_CNT: begin
        if (w_abort) begin
          w_stateNext = S_WAIT;
          w_cntNext   = '0;
          w_rstNext   = '1;
          w_doneNext  = 1'b0;
        end else begin
          // Masking only ever clears bits, so a released channel stays released.
          w_cntNext = w_cntInc;
          w_rstNext = r_rst & ~w_relHit;
          if (w_cntInc == T_LAST) begin
            w_stateNext = S_DONE;
            w_doneNext  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (w_abort) begin
          w_stateNext = S_WAIT;
          w_cntNext   = '0;
          w_rstNext   = '1;
          w_doneNext  = 1'b0;
        end
      end
      default: begin
        w_stateNext = S_WAIT;
        w_cntNext   = '0;
        w_rstNext   = '1;
        w_doneNext  = 1'b0;
      end
    endcase
  end

  assign rst_o  = r_rst;
  assign done_o = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// Randomised and directed bench for rst_seq against a sequence-level model (release after j >= DELAY+k*STEP).
// Runs two instances in parallel: STEP=3 and STEP=0.
module tb_rst_seq;

  localparam int CH  = 3;
  localparam int DLY = 4;
  localparam int STP = 3;
`ifdef RST_SEQ_LOCK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk;
  logic          rstN;
  logic          lockIn;
  logic          retrigIn;
  logic [CH-1:0] rstA;
  logic          doneA;
  logic [CH-1:0] rstB;
  logic          doneB;

  int checkCount = 0;
  int passCount  = 0;

  bit running;
  int j;
  bit lockQ[$];

  rst_seq #(.CH_NUM(CH), .CNT_W(4), .DELAY(4'd4), .STEP(4'd3)) dutA (
    .clk_i(clk), .rst_n_i(rstN), .lock_i(lockIn), .retrig_i(retrigIn),
    .rst_o(rstA), .done_o(doneA)
  );

  rst_seq #(.CH_NUM(CH), .CNT_W(4), .DELAY(4'd4), .STEP(4'd0)) dutB (
    .clk_i(clk), .rst_n_i(rstN), .lock_i(lockIn), .retrig_i(retrigIn),
    .rst_o(rstB), .done_o(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    running = 1'b0;
    j = 0;
    lockQ.delete();
    for (int i = 0; i < LAT; i++) lockQ.push_back(1'b0);
  endtask

  // One clock edge of the model: lock is seen LAT edges late; loss or retrig aborts, else count up.
  task automatic modelEdge();
    bit effLock;
    if (LAT == 0) begin
      effLock = lockIn;
    end else begin
      effLock = lockQ.pop_front();
      lockQ.push_back(lockIn);
    end
    if (!effLock || retrigIn) begin
      running = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      j = 0;
    end else if (j < 1000) begin
      j++;
    end
  endtask

  function automatic logic [CH-1:0] expRst(int d, int s);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = !running || (j < d + k * s);
    return r;
  endfunction

  function automatic logic expDone(int d, int s);
    return running && (j >= d + (CH - 1) * s);
  endfunction

  task automatic checkOne(string tag, string what, logic [CH-1:0] obs, logic [CH-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s %s: observed %b expected %b", tag, what, obs, exp);
  endtask

  task automatic checkOutput(string tag);
    checkOne(tag, "rstA", rstA, expRst(DLY, STP));
    checkOne(tag, "doneA", {2'b00, doneA}, {2'b00, expDone(DLY, STP)});
    checkOne(tag, "rstB", rstB, expRst(DLY, 0));
    checkOne(tag, "doneB", {2'b00, doneB}, {2'b00, expDone(DLY, 0)});
  endtask

  task automatic applyStimulus(bit lk, bit rt, string tag);
    lockIn   = lk;
    retrigIn = rt;
    @(posedge clk);
    if (rstN) modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [CH-1:0] litA;
    logic [CH-1:0] litB;
    int jj;

    rstN     = 1'b0;
    lockIn   = 1'b0;
    retrigIn = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    #1 rstN = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "noLock");

    // First lock: literal release table 111 -> 110 @4 -> 100 @7 -> 000 @10.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b0, "lockSeq");
      jj = i - LAT;
      litA = (jj < 4) ? 3'b111 : (jj < 7) ? 3'b110 : (jj < 10) ? 3'b100 : 3'b000;
      litB = (jj < 4) ? 3'b111 : 3'b000;
      checkOne("lockTable", "rstA", rstA, litA);
      checkOne("lockTable", "doneA", {2'b00, doneA}, {2'b00, jj >= 10});
      checkOne("lockTable", "rstB", rstB, litB);
      checkOne("lockTable", "doneB", {2'b00, doneB}, {2'b00, jj >= 4});
    end

    // Lock loss partway through, then a full restart.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, "lockDrop1");
    for (int i = 0; i < 7 + LAT; i++) applyStimulus(1'b1, 1'b0, "relock1");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, "lockDrop2");
    for (int i = 0; i < 14 + LAT; i++) applyStimulus(1'b1, 1'b0, "relock2");

    // Retrigger while done.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "retrigHold");
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, "retrigRun");

    // Asynchronous reset mid-sequence, checked before any clock edge.
    applyStimulus(1'b1, 1'b1, "retrigPulse");
    for (int i = 0; i < 5 + LAT; i++) applyStimulus(1'b1, 1'b0, "preReset");
    #3 rstN = 1'b0;
    modelReset();
    #1 checkOutput("asyncReset");
    #2 rstN = 1'b1;
    for (int i = 0; i < 14 + LAT; i++) applyStimulus(1'b1, 1'b0, "postReset");

    // Random phase: rare lock loss and retrig.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 29) == 0), "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
